// File: rtl/burst_mem_responder_if.sv
// Bus bundle for burst_mem_responder: request side (addr/burst_len/data_in/rd/wr)
// and response side (data_out/rd_valid/waitrequest).
interface burst_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURSTLEN_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]     addr;
  logic [BURSTLEN_WIDTH-1:0] burst_len;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      wr;
  logic                      rd;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      rd_valid;
  logic                      waitrequest;

  modport master (
    output addr, burst_len, data_in, wr, rd,
    input  data_out, rd_valid, waitrequest
  );

  modport slave (
    input  addr, burst_len, data_in, wr, rd,
    output data_out, rd_valid, waitrequest
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Burst memory target: single-word writes, critical-word-first wrapping read bursts.
// Optional BURST_MEM_STALL_EN adds LFSR-driven stalls in IDLE and BURST.
module burst_mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURSTLEN_WIDTH = 2,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned RD_LATENCY     = 2,
  parameter              MEM_FILE       = ""
) (
  input logic                   clock,
  input logic                   reset,
  burst_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BL_W  = BURSTLEN_WIDTH;
  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAT,
    S_BURST
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t             state_q, state_n;
  logic [BL_W-1:0]    beat_q, beat_n;
  logic [BL_W-1:0]    len_q;
  logic [IDX_W-1:0]   word_q;
  logic [LAT_W-1:0]   lat_q, lat_n;
  logic               rd_valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [IDX_W-1:0]   req_word;
  logic [IDX_W-1:0]   base_word;
  logic [IDX_W-1:0]   beat_word;
  logic               stall, stall_n;
  logic               wr_acc, rd_acc, issue_n;
  logic               unused_addr;

`ifdef BURST_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_n;

  assign lfsr_n = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_n;
  end

  assign stall   = lfsr_q[0];
  assign stall_n = lfsr_n[0];
`else
  assign stall   = 1'b0;
  assign stall_n = 1'b0;
`endif

  assign req_word    = bus.addr[IDX_W+1:2];
  assign unused_addr = ^{bus.addr[ADDR_WIDTH-1:IDX_W+2], bus.addr[1:0]};

  assign bus.waitrequest = reset | (state_q != S_IDLE) | stall;
  assign wr_acc          = bus.wr & ~bus.waitrequest;
  assign rd_acc          = bus.rd & ~bus.wr & ~bus.waitrequest;

  always_comb begin
    state_n   = state_q;
    beat_n    = beat_q;
    lat_n     = lat_q;
    base_word = word_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          base_word = req_word;
          beat_n    = '0;
          if (RD_LATENCY == 1) begin
            state_n = S_BURST;
          end else begin
            state_n = S_LAT;
            lat_n   = LAT_W'(RD_LATENCY - 1);
          end
        end
      end
      S_LAT: begin
        if (lat_q == LAT_W'(1)) state_n = S_BURST;
        else                    lat_n   = lat_q - 1'b1;
      end
      S_BURST: begin
        if (!stall) begin
          if (beat_q == len_q) state_n = S_IDLE;
          else                 beat_n  = beat_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered one cycle ahead: the beat for the next cycle is
  // decided (including next-cycle stall) and its word fetched at this edge.
  assign beat_word = {base_word[IDX_W-1:BL_W], base_word[BL_W-1:0] + beat_n};
  assign issue_n   = (state_n == S_BURST) & ~stall_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      lat_q      <= '0;
      rd_valid_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_n;
      beat_q     <= beat_n;
      lat_q      <= lat_n;
      rd_valid_q <= issue_n;
      if (rd_acc) begin
        word_q <= req_word;
        len_q  <= bus.burst_len;
      end
      if (issue_n) data_q <= mem[beat_word];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[req_word] <= bus.data_in;
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.data_out = data_q;

endmodule
